// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Accepts a start in IDLE, runs one quotient bit per cycle in BUSY, and
// pulses div_done for one cycle in DONE to release the divide stall.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_div,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    localparam int unsigned     CNT_W    = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             sel_rem_q, sel_rem_d;
    logic             neg_q, neg_d;
    logic             busy_q, done_q;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic             sgn_ovf;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN:0]    shifted, diff;
    logic [XLEN-1:0]  rem_step, quo_step;

    // Operand decode: signs, magnitudes and the signed-overflow case
    always_comb begin
        is_signed = ~div_op[0];
        a_neg     = is_signed & rs1_val[XLEN-1];
        b_neg     = is_signed & rs2_val[XLEN-1];
        a_mag     = a_neg ? (-rs1_val) : rs1_val;
        b_mag     = b_neg ? (-rs2_val) : rs2_val;
        sgn_ovf   = is_signed && (rs1_val == INT_MIN) && (rs2_val == ALL_ONES);
    end

    // One restoring step: shift {rem, quotient msb} left and trial-subtract
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            rem_step = diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = shifted[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        neg_d     = neg_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (is_div) begin
                    sel_rem_d = div_op[1];
                    // REM follows the dividend sign, DIV the xor of both signs
                    neg_d     = div_op[1] ? a_neg : (a_neg ^ b_neg);
                    dvs_d     = b_mag;
                    quo_d     = a_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (rs2_val == '0) begin
                        result_d = div_op[1] ? rs1_val : ALL_ONES;
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        result_d = div_op[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (sel_rem_q) begin
                        result_d = neg_q ? (-rem_step) : rem_step;
                    end else begin
                        result_d = neg_q ? (-quo_step) : quo_step;
                    end
                end
            end
            DONE: begin
                // is_div is still high here; ignoring it avoids a restart
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            busy_q    <= (state_d == BUSY);
            done_q    <= (state_d == DONE);
        end
    end

    assign div_busy   = busy_q;
    assign div_done   = done_q;
    assign div_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model with a per-cycle output comparison.
module tb_div_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            is_div;
    logic [1:0]      div_op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model expectations for the current cycle
    bit              chk_en = 1'b0;
    bit              exp_busy, exp_done;
    logic [XLEN-1:0] exp_res;
    int              m_left = 0;
    bit              m_in_done = 1'b0;
    logic [XLEN-1:0] m_pend;

    div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .is_div     (is_div),
        .div_op     (div_op),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb, sr;
        sa = a;
        sb = b;
        if (b == '0) return op[1] ? a : {XLEN{1'b1}};
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : a;
        case (op)
            2'b00:   begin sr = sa / sb; return sr; end
            2'b01:   return a / b;
            2'b10:   begin sr = sa % sb; return sr; end
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [1:0] op,
                                   input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        return (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: what the outputs must be in the cycle after each edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_left    = 0;
            m_in_done = 1'b0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            exp_res   = '0;
            chk_en    = 1'b1;
        end else begin
            exp_done = 1'b0;
            if (m_in_done) begin
                m_in_done = 1'b0;
                exp_busy  = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    exp_busy  = 1'b0;
                    exp_done  = 1'b1;
                    exp_res   = m_pend;
                    m_in_done = 1'b1;
                end
            end else if (is_div) begin
                m_pend = ref_div(div_op, rs1_val, rs2_val);
                if (is_fast(div_op, rs1_val, rs2_val)) begin
                    exp_done  = 1'b1;
                    exp_res   = m_pend;
                    m_in_done = 1'b1;
                end else begin
                    m_left   = XLEN;
                    exp_busy = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check(div_busy === exp_busy, "busy", {31'b0, div_busy}, {31'b0, exp_busy});
            check(div_done === exp_done, "done", {31'b0, div_done}, {31'b0, exp_done});
            check(div_result === exp_res, "result", div_result, exp_res);
        end
    end

    task automatic wait_done(input bit drop, input bit scramble,
                             output int dcyc, output bit seen);
        seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (drop) is_div = 1'b0;
            if (scramble) begin
                rs1_val = $urandom;
                rs2_val = $urandom;
            end
            if (div_done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        if (!seen) check(1'b0, "done_timeout", 32'h0, 32'h1);
    endtask

    // Issue one divide, scramble operands while it runs, check latency/result
    task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] req,
                         input int lat, input string name);
        int n, d;
        bit seen;
        @(negedge clk);
        is_div  = 1'b1;
        div_op  = op;
        rs1_val = a;
        rs2_val = b;
        n = cyc;
        wait_done(1'b1, 1'b1, d, seen);
        if (seen) begin
            check(d - n == lat, {name, "_latency"}, 32'(d - n), 32'(lat));
            check(div_result === req, name, div_result, req);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, d2;
        bit seen;
        logic [1:0]      op;
        logic [XLEN-1:0] a, b;
        int kind;

        rst = 1'b1; is_div = 1'b0; div_op = 2'b00; rs1_val = '0; rs2_val = '0;
        repeat (3) @(negedge clk);
        check(div_busy === 1'b0 && div_done === 1'b0, "reset_flags",
              {30'b0, div_busy, div_done}, 32'h0);
        check(div_result === '0, "reset_result", div_result, 32'h0);
        rst = 1'b0;

        // Hand-computed expectations
        do_op(2'b00, 32'd7,          32'd2,          32'd3,          33, "div_7_2");
        do_op(2'b10, 32'd7,          32'd2,          32'd1,          33, "rem_7_2");
        do_op(2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2");
        do_op(2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div_7_m2");
        do_op(2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem_7_m2");
        do_op(2'b01, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33, "divu_max_2");
        do_op(2'b11, 32'hFFFF_FFFF,  32'd2,          32'd1,          33, "remu_max_2");
        do_op(2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "div_5_0");
        do_op(2'b11, 32'd5,          32'd0,          32'd5,          1,  "remu_5_0");
        do_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf");
        do_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf");

        // is_div held high across DONE; next operands presented in D+1
        @(negedge clk);
        is_div = 1'b1; div_op = 2'b00; rs1_val = 32'd100; rs2_val = 32'd7;
        n = cyc;
        wait_done(1'b0, 1'b0, d, seen);
        if (seen) begin
            check(d - n == 33, "held_first_latency", 32'(d - n), 32'd33);
            check(div_result === 32'd14, "held_first", div_result, 32'd14);
            @(negedge clk);
            rs1_val = 32'd12; rs2_val = 32'd5;
            wait_done(1'b0, 1'b0, d2, seen);
            is_div = 1'b0;
            if (seen) begin
                check(d2 - d == 34, "held_second_latency", 32'(d2 - d), 32'd34);
                check(div_result === 32'd2, "held_second", div_result, 32'd2);
            end
        end
        is_div = 1'b0;

        // Reset in BUSY cycle N+10 aborts the operation
        @(negedge clk);
        is_div = 1'b1; div_op = 2'b01; rs1_val = 32'd1000; rs2_val = 32'd3;
        n = cyc;
        repeat (10) begin
            @(negedge clk);
            is_div = 1'b0;
        end
        check(div_busy === 1'b1, "busy_before_abort", {31'b0, div_busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check(div_busy === 1'b0 && div_done === 1'b0, "abort_flags",
              {30'b0, div_busy, div_done}, 32'h0);
        check(div_result === '0, "abort_result", div_result, 32'h0);
        do_op(2'b01, 32'd1000, 32'd3, 32'd333, 33, "after_abort");

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            op   = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (kind == 0) b = '0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) begin
                a = 32'($urandom_range(0, 50)) - 32'd25;
                b = 32'($urandom_range(1, 9));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            do_op(op, a, b, ref_div(op, a, b), is_fast(op, a, b) ? 1 : 33, "random");
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
